// File: rtl/fetch_queue.sv
// fetch_queue: rv32 instruction-fetch front end.
// Owns the fetch PC, issues requests to a valid/ready instruction memory with
// variable latency, and buffers returned {instruction, PC} pairs in a DEPTH-entry
// in-order queue feeding decode. A redirect flushes the queue and marks all
// in-flight responses for discard.
// Optional build macro: FETCH_MISALIGN_TRAP_EN (adds out_fault; a misaligned
// redirect halts fetch and delivers a single faulting NOP entry).
module fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [XLEN-1:0]            imem_req_addr,
  input  logic                       imem_rsp_valid,
  input  logic [31:0]                imem_rsp_data,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_inst,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_pc_4,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic                       out_fault
`endif
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = $clog2(DEPTH+1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q,   rsp_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_q,     drop_d;
  logic [CW-1:0]   count_q,    count_d;
  logic [PW-1:0]   head_q,     head_d;
  logic [PW-1:0]   tail_q,     tail_d;
  logic            started_q;

  logic [31:0]     inst_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_q   [DEPTH];

  logic            halt;
  logic [CW:0]     pending;
  logic            req_valid;
  logic            req_fire;
  logic            pop;
  logic            push;
  logic [31:0]     wr_inst;
  logic [XLEN-1:0] wr_pc;
  logic [XLEN-1:0] redirect_pc_aligned;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic            fault_mem_q [DEPTH];
  logic            halt_q, halt_d;
  logic            trap_pend_q, trap_pend_d;
  logic [XLEN-1:0] trap_pc_q, trap_pc_d;
  logic            wr_fault;
`endif

  // Request issue gating and handshake decode.
  always_comb begin
`ifdef FETCH_MISALIGN_TRAP_EN
    halt = halt_q;
`else
    halt = 1'b0;
`endif
    pending             = {1'b0, count_q} + {1'b0, inflight_q};
    req_valid           = started_q && !halt && !redirect_valid &&
                          (pending < (CW+1)'(DEPTH));
    req_fire            = req_valid && imem_req_ready;
    pop                 = !redirect_valid && (count_q != '0) && out_ready;
    redirect_pc_aligned = redirect_pc & ~XLEN'(3);
  end

  // Next-state logic for PCs, counters, pointers and the queue write port.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);
    drop_d     = drop_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    push       = 1'b0;
    wr_inst    = imem_rsp_data;
    wr_pc      = rsp_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    halt_d      = halt_q;
    trap_pend_d = trap_pend_q;
    trap_pc_d   = trap_pc_q;
    wr_fault    = 1'b0;
`endif

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc_aligned;
      rsp_pc_d   = redirect_pc_aligned;
      // Every outstanding response is stale after a redirect. Drops still
      // pending from an earlier redirect are already counted in inflight, so
      // the drop count becomes inflight minus the response retiring now.
      drop_d     = inflight_q - CW'(imem_rsp_valid);
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      halt_d      = |redirect_pc[1:0];
      trap_pend_d = |redirect_pc[1:0];
      trap_pc_d   = redirect_pc;
`endif
    end else begin
      if (imem_rsp_valid && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end else if (imem_rsp_valid) begin
        push     = 1'b1;
        rsp_pc_d = rsp_pc_q + XLEN'(4);
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      // While halted every in-flight response is a drop, so once drops
      // drain nothing else can compete for the write port.
      else if (trap_pend_q && (drop_q == '0)) begin
        push        = 1'b1;
        wr_inst     = NOP;
        wr_pc       = trap_pc_q;
        wr_fault    = 1'b1;
        trap_pend_d = 1'b0;
      end
`endif
      if (push) tail_d = tail_q + PW'(1);
      if (pop)  head_d = head_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state registers; issue is enabled one cycle after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      started_q  <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      halt_q      <= 1'b0;
      trap_pend_q <= 1'b0;
      trap_pc_q   <= RESET_PC;
`endif
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      started_q  <= 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
      halt_q      <= halt_d;
      trap_pend_q <= trap_pend_d;
      trap_pc_q   <= trap_pc_d;
`endif
    end
  end

  // Queue storage, written at the tail on push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
        fault_mem_q[i] <= 1'b0;
`endif
      end
    end else if (push) begin
      inst_mem_q[tail_q] <= wr_inst;
      pc_mem_q[tail_q]   <= wr_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_mem_q[tail_q] <= wr_fault;
`endif
    end
  end

  // Output drive.
  always_comb begin
    imem_req_valid = req_valid;
    imem_req_addr  = fetch_pc_q;
    out_valid      = (count_q != '0);
    out_inst       = inst_mem_q[head_q];
    out_pc         = pc_mem_q[head_q];
    out_pc_4       = pc_mem_q[head_q] + XLEN'(4);
    occupancy      = count_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    out_fault      = fault_mem_q[head_q];
`endif
  end

endmodule
